// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone interconnect: owner FSM encoding, default widths
// and a lowest-set-bit helper.
package wb_bus_pkg;

  localparam int unsigned NumUnitsDefault = 8;
  localparam int unsigned AddrWDefault    = 32;
  localparam int unsigned DataWDefault    = 32;
  localparam int unsigned TimeoutDefault  = 255;
  // Widest one-hot vector the helper accepts; callers zero-extend narrower vectors.
  localparam int unsigned MaxUnits        = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOwned   = 2'd1,
    StRelease = 2'd2
  } owner_state_e;

  function automatic int unsigned lowest_set_idx(input logic [MaxUnits-1:0] vec);
    lowest_set_idx = 0;
    for (int unsigned i = MaxUnits; i > 0; i--) begin
      if (vec[i-1]) lowest_set_idx = i - 1;
    end
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall counter: counts enabled cycles, clears on request, flags terminal count.
module wb_timeout_counter
  import wb_bus_pkg::*;
#(
  parameter int unsigned MaxCount = TimeoutDefault
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CntW'(MaxCount));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bus_owner_mux.sv
// Bus-ownership stage behind the arbiter: latches the granted master and routes its classic
// Wishbone cycle to the shared slave. Optional stall timeout under WB_TIMEOUT_EN.
module wb_bus_owner_mux
  import wb_bus_pkg::*;
#(
  parameter int unsigned NUMUNITS       = NumUnitsDefault,
  parameter int unsigned ADDR_W         = AddrWDefault,
  parameter int unsigned DATA_W         = DataWDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMUNITS-1:0]          grant_i,
  output logic [NUMUNITS-1:0]          request_o,
  output logic                         done_o,
  input  logic [NUMUNITS-1:0]          m_cyc_i,
  input  logic [NUMUNITS-1:0]          m_stb_i,
  input  logic [NUMUNITS-1:0]          m_we_i,
  input  logic [NUMUNITS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUMUNITS*DATA_W-1:0]   m_dat_w_i,
  input  logic [NUMUNITS*DATA_W/8-1:0] m_sel_i,
  output logic [NUMUNITS-1:0]          m_ack_o,
  output logic [NUMUNITS-1:0]          m_err_o,
  output logic [DATA_W-1:0]            m_dat_r_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_w_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic [DATA_W-1:0]            s_dat_r_i,
  output logic                         busy_o
);

  localparam int unsigned OwnerW = (NUMUNITS > 1) ? $clog2(NUMUNITS) : 1;
  localparam int unsigned SelW   = DATA_W / 8;

  owner_state_e      state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;

  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [DATA_W-1:0] own_dat_w;
  logic [SelW-1:0]   own_sel;
  logic              timeout;

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_dat_w = '0;
    own_sel   = '0;
    for (int i = 0; i < NUMUNITS; i++) begin
      if (owner_q == OwnerW'(i)) begin
        own_cyc   = m_cyc_i[i];
        own_stb   = m_stb_i[i];
        own_we    = m_we_i[i];
        own_adr   = m_adr_i[i*ADDR_W +: ADDR_W];
        own_dat_w = m_dat_w_i[i*DATA_W +: DATA_W];
        own_sel   = m_sel_i[i*SelW +: SelW];
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  logic tmo_en, tmo_clr, tmo_tc;

  assign tmo_en  = (state_q == StOwned) && own_stb && !s_ack_i && !s_err_i;
  assign tmo_clr = (state_q != StOwned) || !own_stb || s_ack_i || s_err_i;
  assign timeout = (state_q == StOwned) && tmo_tc;

  wb_timeout_counter #(
    .MaxCount(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .en_i (tmo_en),
    .clr_i(tmo_clr),
    .tc_o (tmo_tc)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i != '0) begin
          owner_d = OwnerW'(lowest_set_idx(MaxUnits'(grant_i)));
          state_d = StOwned;
        end
      end
      StOwned: begin
        if (!own_cyc || timeout) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    request_o = m_cyc_i;
    m_dat_r_o = s_dat_r_i;
    done_o    = 1'b0;
    busy_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_w_o = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    unique case (state_q)
      StIdle:    done_o = (grant_i == '0);
      StRelease: done_o = 1'b1;
      StOwned: begin
        busy_o           = 1'b1;
        s_cyc_o          = own_cyc && !timeout;
        s_stb_o          = own_stb && !timeout;
        s_we_o           = own_we;
        s_adr_o          = own_adr;
        s_dat_w_o        = own_dat_w;
        s_sel_o          = own_sel;
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = s_err_i || timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_bus_owner_mux.md
# wb_bus_owner_mux

Shared-bus ownership stage directly downstream of `wb_arbiter`. It consumes the arbiter's registered one-hot `grant` and produces the arbiter's `request` and `done` inputs. It latches the granted master as bus owner and routes that master's Wishbone classic cycle onto the single shared slave port. It returns ack/err/read data to the owner and signals `done` only when ownership may change.

## Interface
- `NUMUNITS`, 8, number of masters (matches arbiter)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `TIMEOUT_CYCLES`, 255, stalled-strobe limit; only used with `WB_TIMEOUT_EN`
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-low
- `grant`  in  NUMUNITS  one-hot grant from arbiter
- `request`  out  NUMUNITS  to arbiter; equals `m_cyc`
- `done`  out  1  to arbiter; re-arbitration permitted
- `m_cyc`, `m_stb`, `m_we`  in  NUMUNITS each  per-master strobes
- `m_adr`  in  NUMUNITS*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- `m_dat_w`  in  NUMUNITS*DATA_W  packed write data
- `m_sel`  in  NUMUNITS*DATA_W/8  packed byte selects
- `m_ack`, `m_err`  out  NUMUNITS each  per-master termination
- `m_dat_r`  out  DATA_W  read data, broadcast to all masters
- `s_cyc`, `s_stb`, `s_we`  out  1 each  shared bus controls
- `s_adr`, `s_dat_w`, `s_sel`  out  ADDR_W, DATA_W, DATA_W/8  shared bus payload
- `s_ack`, `s_err`  in  1 each  slave termination
- `s_dat_r`  in  DATA_W  slave read data
- `busy`  out  1  state is OWNED

## Operation
- FSM states:
  - IDLE: no owner. `done` = (`grant` == 0). If `grant` != 0, latch `owner` = lowest set index and go to OWNED.
  - OWNED: route the owner. If `m_cyc[owner]` = 0, go to RELEASE. `done` = 0.
  - RELEASE: `done` = 1 for exactly one cycle. Always go to IDLE.
- `done` is combinational from state and `grant`. The arbiter loads `grant` only while `done` = 1. This keeps `grant` frozen while a master owns the bus.
- In OWNED:
  - `s_cyc` = `m_cyc[owner]`, `s_stb` = `m_stb[owner]`.
  - `s_we`, `s_adr`, `s_dat_w`, `s_sel` are the owner's slices.
  - `m_ack[owner]` = `s_ack`, `m_err[owner]` = `s_err`. All other m_ack/m_err bits are 0.
- Outside OWNED, every `s_*` output and every `m_ack`/`m_err` bit is 0.
- `m_dat_r` = `s_dat_r` always.
- A master whose `m_cyc` is low when OWNED is entered causes an immediate OWNED→RELEASE.
- Reset: state IDLE, `owner` 0, timeout counter 0.
  - All outputs are 0, except `done`, which follows `grant` == 0.
  - `request` mirrors `m_cyc`.
- Reset asserted mid-transfer aborts the transfer. `s_cyc` drops the cycle after the reset edge.

## Timing
- Master raises `m_cyc` in cycle 0. Arbiter `grant` is valid in cycle 1. OWNED from cycle 2. `s_cyc` is high in cycle 2.
- Master-to-slave and slave-to-master paths in OWNED are zero-latency combinational. Classic single-cycle ack is supported.
- Release overhead: owner drops `m_cyc` in cycle n. RELEASE in n+1. IDLE in n+2. The next owner is in OWNED at n+3 at the earliest.
- Back-to-back transfers by the owner with `m_cyc` held high never release the bus.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each OWNED cycle in which `s_stb` = 1, `s_ack` = 0 and `s_err` = 0.
  - It clears on entering OWNED, on ack/err, and when `s_stb` = 0.
  - When the count equals `TIMEOUT_CYCLES`, in that same cycle: `m_err[owner]` = 1, `s_cyc` and `s_stb` are forced to 0, and next state is RELEASE.
- `WB_TIMEOUT_EN` undefined: no counter. A stalled slave holds the bus indefinitely.

## Structure
- Shared package/header `wb_bus_pkg`:
  - FSM state encodings IDLE=2'd0, OWNED=2'd1, RELEASE=2'd2.
  - Default widths.
  - Lowest-set-bit one-hot-to-index function, reused by other interconnect blocks.
- One sub-module: `wb_timeout_counter` (enable, clear, terminal-count output), instantiated only under `WB_TIMEOUT_EN`.

## Test plan
- After reset, all `m_cyc` = 0 → `done` = 1; `s_cyc` = 0, `m_ack` = 0, `busy` = 0.
- Master 3 raises `m_cyc`/`m_stb` with write to 0x1000 and `grant` = 8'h08 in cycle 1 → `s_cyc` = 1, `s_adr` = 0x1000 in cycle 2; slave ack → `m_ack` = 8'h08 same cycle; `done` = 0 throughout OWNED.
- Masters 1 and 5 both request, round-robin grants 1 first → master 5 is blocked while 1 holds `m_cyc`; 1 drops in cycle n → RELEASE at n+1 with `done` = 1; master 5 owns at n+3.
- Owner holds `m_cyc`, slave returns `s_err` with `s_dat_r` = 0xDEADBEEF → `m_err[owner]` = 1, `m_dat_r` = 0xDEADBEEF; ownership kept.
- With `WB_TIMEOUT_EN` and TIMEOUT_CYCLES = 4, slave never acks → `m_err[owner]` pulses on the 5th stalled cycle; `s_cyc` = 0; RELEASE next.
- Reset pulled low while master 2 is OWNED mid-strobe → state IDLE and `s_cyc` = 0 after the edge; the bus is re-granted normally after reset releases.
